// File: rtl/qeciphy_rx_checker.sv
// qeciphy_rx_checker: checks an incrementing 64-bit word stream from the
// QECI-PHY AXI-Stream RX port. It locks after LOCK_COUNT consecutive
// in-sequence words, counts words and mismatches while locked, and drops
// back to seeking after LOSS_COUNT consecutive mismatches.
//
// Optional feature: define QECIPHY_RX_CHECKER_CAPTURE_EN to add first-error
// capture registers (first_err_data / first_err_exp).
//
// Ports:
//   ACLK, rst_n          clock, async active-low reset
//   enable               checker run enable
//   clear                synchronous clear of counters, sticky flags, capture
//   RX_TDATA/RX_TVALID   received word and its valid
//   RX_TREADY            always ready once out of reset
//   locked               checker is in LOCKED
//   err_flag, loss_flag  sticky mismatch-while-locked / lock-lost flags
//   word_count           words accepted while locked (saturating)
//   err_count            mismatching words while locked (saturating)
//   first_err_data/exp   received/expected value of first mismatch (optional)
module qeciphy_rx_checker #(
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned LOSS_COUNT = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             ACLK,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [63:0]      RX_TDATA,
    input  logic             RX_TVALID,
    output logic             RX_TREADY,
    output logic             locked,
    output logic             err_flag,
    output logic             loss_flag,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count
`ifdef QECIPHY_RX_CHECKER_CAPTURE_EN
    ,
    output logic [63:0]      first_err_data,
    output logic [63:0]      first_err_exp
`endif
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned RUN_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              locked_q, locked_d;
    logic              err_flag_q, err_flag_d;
    logic              loss_flag_q, loss_flag_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [DATA_W-1:0] expected_q, expected_d;
    logic [RUN_W-1:0]  match_run_q, match_run_d;
    logic [RUN_W-1:0]  miss_run_q, miss_run_d;
`ifdef QECIPHY_RX_CHECKER_CAPTURE_EN
    logic [DATA_W-1:0] cap_data_q, cap_data_d;
    logic [DATA_W-1:0] cap_exp_q, cap_exp_d;
`endif

    logic accept_c;
    logic mismatch_c;

    assign accept_c   = RX_TVALID && ready_q;
    assign mismatch_c = (RX_TDATA != expected_q);

    // State register and all output/datapath flops
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            locked_q     <= 1'b0;
            err_flag_q   <= 1'b0;
            loss_flag_q  <= 1'b0;
            word_count_q <= '0;
            err_count_q  <= '0;
            expected_q   <= '0;
            match_run_q  <= '0;
            miss_run_q   <= '0;
`ifdef QECIPHY_RX_CHECKER_CAPTURE_EN
            cap_data_q   <= '0;
            cap_exp_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            locked_q     <= locked_d;
            err_flag_q   <= err_flag_d;
            loss_flag_q  <= loss_flag_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
            expected_q   <= expected_d;
            match_run_q  <= match_run_d;
            miss_run_q   <= miss_run_d;
`ifdef QECIPHY_RX_CHECKER_CAPTURE_EN
            cap_data_q   <= cap_data_d;
            cap_exp_q    <= cap_exp_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        ready_d      = 1'b1;
        err_flag_d   = err_flag_q;
        loss_flag_d  = loss_flag_q;
        word_count_d = word_count_q;
        err_count_d  = err_count_q;
        expected_d   = expected_q;
        match_run_d  = match_run_q;
        miss_run_d   = miss_run_q;
`ifdef QECIPHY_RX_CHECKER_CAPTURE_EN
        cap_data_d   = cap_data_q;
        cap_exp_d    = cap_exp_q;
`endif

        if (!enable) begin
            // Dropping enable parks the FSM but keeps every count and flag
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SEEK;
                end
                SEEK: begin
                    if (accept_c) begin
                        expected_d = RX_TDATA + DATA_W'(1);
                        if (!mismatch_c) begin
                            match_run_d = (match_run_q == RUN_MAX) ? match_run_q
                                                                   : match_run_q + RUN_W'(1);
                        end else begin
                            match_run_d = RUN_W'(1);
                        end
                        // >= keeps lock reachable if a stale run was held across IDLE
                        if (match_run_d >= RUN_W'(LOCK_COUNT)) begin
                            state_d    = LOCKED;
                            miss_run_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (accept_c) begin
                        // Expected free-runs so a single corrupt word costs one error
                        expected_d   = expected_q + DATA_W'(1);
                        word_count_d = (word_count_q == CNT_MAX) ? word_count_q
                                                                 : word_count_q + CNT_W'(1);
                        if (mismatch_c) begin
                            err_count_d = (err_count_q == CNT_MAX) ? err_count_q
                                                                   : err_count_q + CNT_W'(1);
                            err_flag_d  = 1'b1;
                            miss_run_d  = (miss_run_q == RUN_MAX) ? miss_run_q
                                                                  : miss_run_q + RUN_W'(1);
`ifdef QECIPHY_RX_CHECKER_CAPTURE_EN
                            if (!err_flag_q) begin
                                cap_data_d = RX_TDATA;
                                cap_exp_d  = expected_q;
                            end
`endif
                        end else begin
                            miss_run_d = '0;
                        end
                        if (miss_run_d >= RUN_W'(LOSS_COUNT)) begin
                            state_d     = SEEK;
                            loss_flag_d = 1'b1;
                            match_run_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Clear wins over any increment or flag set on the same edge
        if (clear) begin
            err_flag_d   = 1'b0;
            loss_flag_d  = 1'b0;
            word_count_d = '0;
            err_count_d  = '0;
`ifdef QECIPHY_RX_CHECKER_CAPTURE_EN
            cap_data_d   = '0;
            cap_exp_d    = '0;
`endif
        end

        locked_d = (state_d == LOCKED);
    end

    assign RX_TREADY  = ready_q;
    assign locked     = locked_q;
    assign err_flag   = err_flag_q;
    assign loss_flag  = loss_flag_q;
    assign word_count = word_count_q;
    assign err_count  = err_count_q;
`ifdef QECIPHY_RX_CHECKER_CAPTURE_EN
    assign first_err_data = cap_data_q;
    assign first_err_exp  = cap_exp_q;
`endif

endmodule

// File: tb/tb_qeciphy_rx_checker.sv
// Directed self-checking bench for qeciphy_rx_checker (CNT_W=4 so that
// counter saturation is reachable in a short run).
module tb_qeciphy_rx_checker;

    localparam int unsigned CNT_W = 4;

    logic             ACLK;
    logic             rst_n;
    logic             enable;
    logic             clear;
    logic [63:0]      RX_TDATA;
    logic             RX_TVALID;
    logic             RX_TREADY;
    logic             locked;
    logic             err_flag;
    logic             loss_flag;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] err_count;
`ifdef QECIPHY_RX_CHECKER_CAPTURE_EN
    logic [63:0]      first_err_data;
    logic [63:0]      first_err_exp;
`endif

    int n_chk = 0;
    int n_err = 0;

    qeciphy_rx_checker #(
        .LOCK_COUNT(8),
        .LOSS_COUNT(4),
        .CNT_W     (CNT_W)
    ) dut (
        .ACLK      (ACLK),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .RX_TDATA  (RX_TDATA),
        .RX_TVALID (RX_TVALID),
        .RX_TREADY (RX_TREADY),
        .locked    (locked),
        .err_flag  (err_flag),
        .loss_flag (loss_flag),
        .word_count(word_count),
        .err_count (err_count)
`ifdef QECIPHY_RX_CHECKER_CAPTURE_EN
        ,
        .first_err_data(first_err_data),
        .first_err_exp (first_err_exp)
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic step(input logic v, input logic [63:0] d);
        RX_TVALID = v;
        RX_TDATA  = d;
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tready"}, 64'(RX_TREADY), 64'd0);
        chk({tag, "_locked"}, 64'(locked), 64'd0);
        chk({tag, "_err_flag"}, 64'(err_flag), 64'd0);
        chk({tag, "_loss_flag"}, 64'(loss_flag), 64'd0);
        chk({tag, "_word_count"}, 64'(word_count), 64'd0);
        chk({tag, "_err_count"}, 64'(err_count), 64'd0);
`ifdef QECIPHY_RX_CHECKER_CAPTURE_EN
        chk({tag, "_cap_data"}, first_err_data, 64'd0);
        chk({tag, "_cap_exp"}, first_err_exp, 64'd0);
`endif
    endtask

    initial begin
        logic [63:0] e;
        rst_n     = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        RX_TVALID = 1'b0;
        RX_TDATA  = 64'd0;

        // Reset values, then release just after an edge
        #12;
        chk_all_zero("reset");
        @(posedge ACLK);
        #1;
        rst_n = 1'b1;
        step(1'b0, 64'd0);
        chk("tready_after_release", 64'(RX_TREADY), 64'd1);

        // IDLE -> SEEK
        enable = 1'b1;
        step(1'b0, 64'd0);
        chk("seek_not_locked", 64'(locked), 64'd0);

        // Lock on incrementing stream from 0x10
        for (int i = 0; i < 7; i++) step(1'b1, 64'h10 + 64'(i));
        chk("lock_after7", 64'(locked), 64'd0);
        step(1'b1, 64'h17);
        chk("lock_after8", 64'(locked), 64'd1);
        chk("lock_wc0", 64'(word_count), 64'd0);
        chk("lock_ec0", 64'(err_count), 64'd0);

        for (int i = 0; i < 3; i++) step(1'b1, 64'h18 + 64'(i));
        chk("wc_3", 64'(word_count), 64'd3);

        // Continue to 0xFF: 232 locked words saturate a 4-bit count at 15
        for (int i = 0; i < 229; i++) step(1'b1, 64'h1B + 64'(i));
        chk("wc_saturate", 64'(word_count), 64'd15);
        chk("no_err_stream", 64'(err_count), 64'd0);
        step(1'b0, 64'h0);
        chk("idle_cycle_locked", 64'(locked), 64'd1);

        // Clear keeps the FSM state
        clear = 1'b1;
        step(1'b0, 64'h0);
        clear = 1'b0;
        chk("clear_wc", 64'(word_count), 64'd0);
        chk("clear_keeps_lock", 64'(locked), 64'd1);

        // Single corrupt word (expected 0x100)
        step(1'b1, 64'hDEAD);
        chk("corrupt_ec", 64'(err_count), 64'd1);
        chk("corrupt_flag", 64'(err_flag), 64'd1);
        chk("corrupt_locked", 64'(locked), 64'd1);
        chk("corrupt_wc", 64'(word_count), 64'd1);
`ifdef QECIPHY_RX_CHECKER_CAPTURE_EN
        chk("cap_data", first_err_data, 64'hDEAD);
        chk("cap_exp", first_err_exp, 64'h100);
`endif
        step(1'b1, 64'h101);
        chk("resync_ec", 64'(err_count), 64'd1);
        chk("resync_wc", 64'(word_count), 64'd2);
        step(1'b0, 64'h0);
        step(1'b0, 64'h0);
        chk("novalid_wc", 64'(word_count), 64'd2);

        // Four consecutive wrong words lose lock (expected 0x102..0x105)
        for (int i = 0; i < 3; i++) step(1'b1, 64'hBAD0 + 64'(i));
        chk("miss3_locked", 64'(locked), 64'd1);
        chk("miss3_loss", 64'(loss_flag), 64'd0);
        step(1'b1, 64'hBAD3);
        chk("miss4_locked", 64'(locked), 64'd0);
        chk("miss4_loss", 64'(loss_flag), 64'd1);
        chk("miss4_ec", 64'(err_count), 64'd5);
        chk("miss4_wc", 64'(word_count), 64'd6);

        // Relock on a fresh sequence from 0x200
        for (int i = 0; i < 7; i++) step(1'b1, 64'h200 + 64'(i));
        chk("relock_after7", 64'(locked), 64'd0);
        step(1'b1, 64'h207);
        chk("relock_after8", 64'(locked), 64'd1);

        // Alternating wrong/right words: err_count saturates, lock holds
        e = 64'h208;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, ~e);
            e = e + 64'd1;
            step(1'b1, e);
            e = e + 64'd1;
            if (i == 9) chk("ec_reach_max", 64'(err_count), 64'd15);
        end
        chk("ec_saturate", 64'(err_count), 64'd15);
        chk("alt_locked", 64'(locked), 64'd1);

        // Disable holds counters
        enable = 1'b0;
        step(1'b1, 64'h0);
        chk("disable_locked", 64'(locked), 64'd0);
        chk("disable_ec_hold", 64'(err_count), 64'd15);
        chk("disable_loss_hold", 64'(loss_flag), 64'd1);
        enable = 1'b1;
        step(1'b0, 64'h0);
        clear = 1'b1;
        step(1'b0, 64'h0);
        clear = 1'b0;

        // Lock at 0x...F0..F7, then run locked through the 64-bit wrap
        for (int i = 0; i < 8; i++) step(1'b1, 64'hFFFF_FFFF_FFFF_FFF0 + 64'(i));
        chk("wrap_lock", 64'(locked), 64'd1);
        for (int i = 8; i < 20; i++) step(1'b1, 64'hFFFF_FFFF_FFFF_FFF0 + 64'(i));
        chk("wrap_ec", 64'(err_count), 64'd0);
        chk("wrap_wc", 64'(word_count), 64'd12);
        chk("wrap_locked", 64'(locked), 64'd1);

        // Clear on the same edge as a mismatch (expected 0x4)
        clear = 1'b1;
        step(1'b1, 64'h999);
        clear = 1'b0;
        chk("clrmis_ec", 64'(err_count), 64'd0);
        chk("clrmis_flag", 64'(err_flag), 64'd0);
        chk("clrmis_wc", 64'(word_count), 64'd0);
        chk("clrmis_locked", 64'(locked), 64'd1);
`ifdef QECIPHY_RX_CHECKER_CAPTURE_EN
        chk("clrmis_cap", first_err_data, 64'd0);
`endif

        // Async reset while locked with valid high
        step(1'b1, 64'h5);
        chk("pre_rst_wc", 64'(word_count), 64'd1);
        RX_TVALID = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge ACLK);
        #1;
        rst_n = 1'b1;
        step(1'b1, 64'h6);
        chk("rel_tready", 64'(RX_TREADY), 64'd1);
        chk("rel_wc", 64'(word_count), 64'd0);
        chk("rel_locked", 64'(locked), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
